// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shift type codes, FSM states and effective-amount helper
package shift_sequencer_pkg;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } seqState;

    // Amounts past 33 cannot change a linear shift; ROR only cares about amt mod 32,
    // but a nonzero multiple of 32 must still run 32 bits so the carry becomes bit 31.
    function automatic logic [5:0] effAmount(input logic [1:0] sh, input logic [7:0] amt);
        if (sh == SH_ROR) begin
            if (amt == 8'd0)
                return 6'd0;
            else if (amt[4:0] == 5'd0)
                return 6'd32;
            else
                return {1'b0, amt[4:0]};
        end else if (amt > 8'd33) begin
            return 6'd33;
        end else begin
            return amt[5:0];
        end
    endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// rtl/shift_sequencer_shifter.sv - combinational 32-bit shifter with 5-bit amount
import shift_sequencer_pkg::*;

module shift_sequencer_shifter (
    input  logic [1:0]  Sh,
    input  logic [4:0]  Shamt5,
    input  logic [31:0] ShIn,
    output logic [31:0] ShOut
);

    always_comb begin
        ShOut = ShIn;
        case (Sh)
            SH_LSL:  ShOut = ShIn << Shamt5;
            SH_LSR:  ShOut = ShIn >> Shamt5;
            SH_ASR:  ShOut = 32'($signed(ShIn) >>> Shamt5);
            default: ShOut = (ShIn >> Shamt5) | (ShIn << (6'd32 - {1'b0, Shamt5}));
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle register-amount shift controller with ARM carry-out
import shift_sequencer_pkg::*;

module shift_sequencer #(
    parameter int MAX_STEP = 31
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  Sh,
    input  logic [7:0]  Amt8,
    input  logic [31:0] ShIn,
    input  logic        CarryIn,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] ShOut,
    output logic        CarryOut
);

    localparam logic [5:0] STEP = 6'(MAX_STEP);

    seqState     state, nextState;
    logic [31:0] val, valNext, stepOut, shOutReg;
    logic [5:0]  rem, remNext, k, lslIdx, lsrIdx;
    logic [1:0]  shReg;
    logic        c, cNext, carryOutReg;

    shift_sequencer_shifter uShifter (
        .Sh     (shReg),
        .Shamt5 (k[4:0]),
        .ShIn   (val),
        .ShOut  (stepOut)
    );

    assign lslIdx = 6'd32 - k;
    assign lsrIdx = k - 6'd1;

    always_ff @(posedge CLK) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        k         = 6'd0;
        valNext   = val;
        cNext     = c;
        remNext   = rem;
        case (state)
            S_IDLE: begin
                if (ReqValid) begin
                    valNext   = ShIn;
                    cNext     = CarryIn;
                    remNext   = effAmount(Sh, Amt8);
                    nextState = (remNext == 6'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                k       = (rem > STEP) ? STEP : rem;
                valNext = stepOut;
                remNext = rem - k;
                case (shReg)
                    SH_LSL:  cNext = val[lslIdx[4:0]];
                    SH_ROR:  cNext = stepOut[31];
                    default: cNext = val[lsrIdx[4:0]];
                endcase
                if (remNext == 6'd0)
                    nextState = S_DONE;
            end
            S_DONE: begin
                if (RspReady)
                    nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    // Result registers load only on entry to DONE so the outputs hold between operations.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            val         <= 32'd0;
            c           <= 1'b0;
            rem         <= 6'd0;
            shReg       <= SH_LSL;
            shOutReg    <= 32'd0;
            carryOutReg <= 1'b0;
        end else begin
            val <= valNext;
            c   <= cNext;
            rem <= remNext;
            if (state == S_IDLE && ReqValid)
                shReg <= Sh;
            if (nextState == S_DONE && state != S_DONE) begin
                shOutReg    <= valNext;
                carryOutReg <= cNext;
            end
        end
    end

    assign ReqReady = (state == S_IDLE);
    assign RspValid = (state == S_DONE);
    assign ShOut    = shOutReg;
    assign CarryOut = carryOutReg;

endmodule
